// File: rtl/nibble_add_seq.sv
// Multi-cycle N-nibble adder/subtractor built around one 4-bit ripple slice.
// One nibble per clock, LSB nibble first, carry held in a register between slices.
module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 c_in,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 c_out,
    output logic                 ovf
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [IW-1:0]   idx;
    logic            carry;

    logic [3:0]      sa;
    logic [3:0]      sb;
    logic [3:0]      ss;
    logic [4:0]      sc;
    logic            last;

    // Four chained full adders; this is the only combinational carry path.
    always_comb begin
        sa    = a_reg[4*idx +: 4];
        sb    = b_reg[4*idx +: 4];
        sc    = '0;
        ss    = '0;
        sc[0] = carry;
        for (int i = 0; i < 4; i++) begin
            ss[i]   = sa[i] ^ sb[i] ^ sc[i];
            sc[i+1] = (sa[i] & sb[i]) | (sc[i] & (sa[i] ^ sb[i]));
        end
    end

    assign last = (idx == IW'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b ^ {W{sub}};
                        carry <= sub | c_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= ss;
                    carry           <= sc[4];
                    if (last) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        c_out <= sc[4];
                        ovf   <= (a_reg[W-1] == b_reg[W-1]) && (ss[3] != a_reg[W-1]);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq (NIBBLES=4): vector table plus
// hand-written sequences for reset, ignored start and back-to-back runs.
module tb_nibble_add_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;

    int checks;
    int errors;

    nibble_add_seq #(.NIBBLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called right after the accepting edge; counts further edges until done.
    task automatic wait_done(output int edges);
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) return;
            @(posedge clk);
            edges++;
        end
        checks++;
        errors++;
        $display("FAIL timeout: done never seen within 20 edges");
        edges = -1;
    endtask

    // Called at a negedge; leaves the bench #1 after the accepting edge.
    task automatic launch(input logic [15:0] va, input logic [15:0] vb,
                          input logic vs, input logic vc);
        a     = va;
        b     = vb;
        sub   = vs;
        c_in  = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [15:0] es,
                                input logic ec, input logic eo);
        chk({tag, " sum"}, 32'(sum), 32'(es));
        chk({tag, " c_out"}, 32'(c_out), 32'(ec));
        chk({tag, " ovf"}, 32'(ovf), 32'(eo));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " sum"}, 32'(sum), 32'd0);
        chk({tag, " c_out"}, 32'(c_out), 32'd0);
        chk({tag, " ovf"}, 32'(ovf), 32'd0);
    endtask

    int e;

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0};

        // Reset with start held high: reset wins.
        reset = 1'b1;
        start = 1'b1;
        sub   = 1'b0;
        c_in  = 1'b0;
        a     = 16'h1234;
        b     = 16'h4321;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");

        // Release reset with start still high: accepted on the next edge.
        reset = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("post_reset busy", 32'(busy), 32'd1);
        @(posedge clk);
        wait_done(e);
        chk("post_reset latency", 32'(e + 1), 32'd4);
        check_result("post_reset", 16'h5555, 1'b0, 1'b0);

        // Table-driven vectors.
        foreach (vecs[i]) begin
            @(negedge clk);
            launch(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin);
            a    = ~vecs[i].a;
            b    = ~vecs[i].b;
            c_in = ~vecs[i].cin;
            sub  = ~vecs[i].sub;
            wait_done(e);
            chk($sformatf("vec%0d latency", i), 32'(e), 32'd4);
            check_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            @(negedge clk);
            chk($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d sum_hold", i), 32'(sum), 32'(vecs[i].sum));
        end

        // Start pulsed in RUN cycle 2 with other operands is ignored.
        @(negedge clk);
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        fork
            wait_done(e);
            begin
                @(posedge clk);
                @(negedge clk);
                a     = 16'hFFFF;
                b     = 16'hFFFF;
                sub   = 1'b1;
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
        join
        chk("ignore latency", 32'(e), 32'd4);
        check_result("ignore", 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        chk("ignore idle busy", 32'(busy), 32'd0);
        chk("ignore idle done", 32'(done), 32'd0);

        // Back-to-back: start held, second op accepted in the DONE cycle.
        a     = 16'h1111;
        b     = 16'h2222;
        sub   = 1'b0;
        c_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(e);
        chk("b2b first latency", 32'(e), 32'd4);
        check_result("b2b first", 16'h3333, 1'b0, 1'b0);
        a = 16'h0F0F;
        b = 16'h0101;
        @(posedge clk);
        #1;
        wait_done(e);
        chk("b2b period", 32'(e + 1), 32'd5);
        check_result("b2b second", 16'h1010, 1'b0, 1'b0);
        start = 1'b0;
        @(negedge clk);
        chk("b2b stop busy", 32'(busy), 32'd0);
        chk("b2b stop done", 32'(done), 32'd0);

        // Leave c_out/ovf set, then abort a run with reset.
        launch(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_done(e);
        check_result("pre_abort", 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        launch(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        begin
            int seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1;
            end
            chk("abort no_done", 32'(seen), 32'd0);
        end

        // Fresh start after the abort completes normally.
        launch(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        wait_done(e);
        chk("fresh latency", 32'(e), 32'd4);
        check_result("fresh", 16'h1000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
